// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad reader constants and one-hot column codes
package keypad_pkg;
  localparam int CLK_FREQ_HZ = 27_000_000;
  localparam int COL_W = 4;
  localparam int SCAN_DWELL = 27_000;
  localparam logic [COL_W-1:0] COL0 = 4'b1000;
  localparam logic [COL_W-1:0] COL1 = 4'b0100;
  localparam logic [COL_W-1:0] COL2 = 4'b0010;
  localparam logic [COL_W-1:0] COL3 = 4'b0001;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser exposing both stages, sync reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic meta,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q <= 1'b0;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/debounce.sv
// debounce: keypad row debouncer that latches the scanned column on press acceptance
module debounce
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 8192,
  parameter int COL_W = keypad_pkg::COL_W
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             button_in,
  input  logic [COL_W-1:0] columnas,
  output logic             DB_out,
  output logic [COL_W-1:0] columna_presionada
);
  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  logic s0, s1, accept;
  logic [CNT_W-1:0] cnt, cnt_next;
  sync_2ff u_sync (
    .clk(clk),
    .rst(n_reset),
    .d(button_in),
    .meta(s0),
    .q(s1)
  );
  always_comb begin
    cnt_next = (s0 != s1) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    accept = (s0 == s1) && (cnt == CNT_MAX) && (s1 != DB_out);
  end
  // the captured column is cleared on release so the reader's OR of all rows stays clean
  always_ff @(posedge clk) begin
    if (n_reset) begin
      cnt <= '0;
      DB_out <= 1'b0;
      columna_presionada <= '0;
    end else begin
      cnt <= cnt_next;
      if (accept) begin
        DB_out <= s1;
        columna_presionada <= s1 ? columnas : '0;
      end
    end
  end
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: directed vector table plus hand sequences for debounce with STABLE_CYCLES=4
module tb_debounce;
  import keypad_pkg::*;
  typedef struct {
    logic rst;
    logic btn;
    logic [3:0] col;
    logic db;
    logic [3:0] pc;
  } vec_t;
  localparam int NV = 66;
  logic clk = 1'b0;
  logic n_reset = 1'b1;
  logic button_in = 1'b0;
  logic [3:0] columnas = 4'b0000;
  logic DB_out;
  logic [3:0] columna_presionada;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv [NV];
  logic [3:0] scan [4];
  debounce #(.STABLE_CYCLES(4), .COL_W(4)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .button_in(button_in),
    .columnas(columnas),
    .DB_out(DB_out),
    .columna_presionada(columna_presionada)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic r, input logic b, input logic [3:0] c);
    n_reset = r;
    button_in = b;
    columnas = c;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic db, input logic [3:0] pc);
    n_cmp++;
    if (DB_out !== db || columna_presionada !== pc) begin
      n_bad++;
      $display("FAIL %s: got DB_out=%b col=%b, expected DB_out=%b col=%b",
               name, DB_out, columna_presionada, db, pc);
    end
  endtask
  task automatic set_v(input int i, input logic r, input logic b, input logic [3:0] c,
                       input logic db, input logic [3:0] pc);
    tv[i] = '{rst: r, btn: b, col: c, db: db, pc: pc};
  endtask
  initial begin
    scan[0] = COL2; scan[1] = COL3; scan[2] = COL0; scan[3] = COL1;
    for (int i = 0; i < 3; i++) set_v(i, 1'b1, 1'b1, COL1, 1'b0, 4'b0000);
    for (int i = 3; i < 10; i++) set_v(i, 1'b0, 1'b0, COL1, 1'b0, 4'b0000);
    for (int i = 10; i < 15; i++) set_v(i, 1'b0, 1'b1, COL1, 1'b0, 4'b0000);
    set_v(15, 1'b0, 1'b1, COL1, 1'b1, COL1);
    for (int i = 16; i < 40; i++) set_v(i, 1'b0, 1'b1, scan[i % 4], 1'b1, COL1);
    for (int i = 40; i < 45; i++) set_v(i, 1'b0, 1'b0, COL1, 1'b1, COL1);
    set_v(45, 1'b0, 1'b0, COL1, 1'b0, 4'b0000);
    for (int i = 46; i < NV; i++) set_v(i, 1'b0, 1'b0, COL2, 1'b0, 4'b0000);
    tv[50].btn = 1'b1; tv[51].btn = 1'b1; tv[52].btn = 1'b1;
    tv[54].btn = 1'b1; tv[55].btn = 1'b1;
    for (int i = 0; i < NV; i++) begin
      cyc(tv[i].rst, tv[i].btn, tv[i].col);
      chk($sformatf("vec%0d", i), tv[i].db, tv[i].pc);
    end
    // press whose accepting edge coincides with a column change captures the new column
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, COL0);
      chk($sformatf("scan_rise%0d", i), 1'b0, 4'b0000);
    end
    cyc(1'b0, 1'b1, COL2);
    chk("scan_accept", 1'b1, COL2);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, COL3);
      chk($sformatf("scan_hold%0d", i), 1'b1, COL2);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, COL3);
      chk($sformatf("scan_rel%0d", i), 1'b1, COL2);
    end
    cyc(1'b0, 1'b0, COL3);
    chk("scan_released", 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, COL1);
      chk($sformatf("midcnt_pre%0d", i), 1'b0, 4'b0000);
    end
    cyc(1'b1, 1'b1, COL1);
    chk("midcnt_reset", 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, COL1);
      chk($sformatf("midcnt_post%0d", i), 1'b0, 4'b0000);
    end
    cyc(1'b0, 1'b1, COL1);
    chk("midcnt_accept", 1'b1, COL1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, COL1);
    cyc(1'b0, 1'b0, COL1);
    chk("midcnt_release", 1'b0, 4'b0000);
    // non-one-hot drive is captured as-is
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'b1111);
    cyc(1'b0, 1'b1, 4'b1010);
    chk("nonhot_capture", 1'b1, 4'b1010);
    cyc(1'b1, 1'b1, 4'b1010);
    chk("reset_while_high", 1'b0, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/debounce.md
Name: debounce

Overview:
- Debounces one keypad row line (`button_in`, active-high = key pressed in the currently driven column).
- Reports which column was being scanned when the debounced press was accepted.
- Four instances, one per row, sit in the keypad reader next to the column-scan FSM. That FSM drives a one-hot `columnas` at 27 MHz and advances every 27 000 cycles (1 ms).
- The reader ORs the four `columna_presionada` outputs and decodes them against the debounced rows.

Parameters:
- STABLE_CYCLES, 8192: consecutive cycles the synchronised input must hold a level before `DB_out` follows it. Must be less than the column dwell (27 000).
- COL_W, 4: width of the column bus.
- CNT_W, $clog2(STABLE_CYCLES)+1: stability counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, 27 MHz nominal; all logic on rising edge.
- n_reset  input  1  reset, synchronous, active-high (asserted = 1 despite the name).
- button_in  input  1  raw, asynchronous, bouncy row level.
- columnas  input  COL_W  current one-hot column drive from the scan FSM.
- DB_out  output  1  debounced row level.
- columna_presionada  output  COL_W  column captured at press acceptance; zero when `DB_out`=0.

Behaviour:
- Reset (`n_reset`=1 at a clock edge):
  - sync0, sync1, `DB_out`, counter and `columna_presionada` all go to 0 on that edge.
  - Reset mid-count discards the count.
  - Reset has priority over all other updates.
- Synchroniser: sync0 <= `button_in`; sync1 <= sync0. There is no other use of the raw input.
- Stability counter:
  - Resets to 0 on any edge where sync0 != sync1.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- DB_out:
  - DB_out <= sync1 on an edge where counter == STABLE_CYCLES-1 and sync0 == sync1; otherwise it holds.
  - Latency: a clean 0->1 on `button_in` first sampled at edge E gives `DB_out`=1 after edge E+STABLE_CYCLES+1. Release has the same latency.
  - Any bounce or glitch shorter than STABLE_CYCLES cycles (after synchronisation) produces no change on `DB_out`.
  - A bounce during counting restarts the count from 0.
- columna_presionada:
  - On the edge where `DB_out` goes 0->1, it captures `columnas` as sampled on that same edge.
  - It holds while `DB_out` stays 1, even though `columnas` keeps scanning.
  - On the edge where `DB_out` goes 1->0, it clears to 0.
  - It is never nonzero while `DB_out`=0. This keeps the reader's OR clean.
- Scan interaction:
  - A held key raises `button_in` only while its column is driven, so `DB_out` pulses about once per 4 ms.
  - Each pulse lasts roughly dwell minus debounce time, with a freshly captured column each time.
- Non-one-hot `columnas` is captured verbatim, with no checking.
- Simultaneous events: reset wins over a rise/fall decision. A rise and a column change on the same edge capture the new sampled `columnas` value.

Decomposition:
- Shared package `keypad_pkg`:
  - constants CLK_FREQ_HZ=27_000_000, COL_W=4, SCAN_DWELL=27_000;
  - one-hot column constants COL0=4'b1000, COL1=4'b0100, COL2=4'b0010, COL3=4'b0001.
- One sub-module is natural: `sync_2ff` (2-flop synchroniser, synchronous active-high reset to 0), instantiated for `button_in`.
- The counter and capture logic stay in debounce.

Test Plan (bench uses STABLE_CYCLES=4):
- Reset: drive `n_reset`=1 with `button_in`=1 and `columnas`=4'b0100 for 3 cycles -> `DB_out`=0 and `columna_presionada`=0 on every edge while reset is asserted.
- Clean press: `button_in` 0->1 sampled at edge 10, `columnas`=4'b0100 -> `DB_out`=1 first after edge 15; `columna_presionada`=4'b0100 from the same edge.
- Bounce rejection: `button_in` high 3 cycles, low 1, high 2, low -> `DB_out` stays 0; `columna_presionada` stays 0.
- Hold across scan: after acceptance with `columnas`=4'b0010, switch `columnas` to 4'b0001 while `button_in` stays 1 -> `columna_presionada` remains 4'b0010.
- Release: `button_in` 1->0 sampled at edge 40 -> `DB_out`=0 after edge 45; `columna_presionada`=0 on that same edge.
- Reset mid-count: `button_in` high for 3 cycles, then `n_reset` pulse for 1 cycle, `button_in` still high -> count restarts; `DB_out` rises STABLE_CYCLES+1 edges after reset deassertion, not earlier.
